// File: rtl/hdmiext_pkg.sv
// hdmiext_pkg: TMDS control-period words and lane indices shared by the HDMI extension path
package hdmiext_pkg;

    localparam logic [9:0] CTRL0 = 10'b1101010100;
    localparam logic [9:0] CTRL1 = 10'b0010101011;
    localparam logic [9:0] CTRL2 = 10'b0101010100;
    localparam logic [9:0] CTRL3 = 10'b1010101011;

    localparam int BLUE  = 0;
    localparam int GREEN = 1;
    localparam int RED   = 2;

endpackage

// File: rtl/hdmiext_pad_diff.sv
// hdmiext_pad_diff: registered differential pad pair; HDMIEXT_SEROUT_OBUFDS_EN selects an OBUFDS primitive
module hdmiext_pad_diff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_p,
    output logic o_n
);

`ifdef HDMIEXT_SEROUT_OBUFDS_EN
    logic r_q;

    // single registered bit feeding the differential buffer
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_q <= RST_VAL;
        else          r_q <= i_d;

    OBUFDS #(.IOSTANDARD("TMDS_33")) u_obufds (.I(r_q), .O(o_p), .OB(o_n));
`else
    logic r_p;
    logic r_n;

    // true and complement registered separately so both legs switch on the same edge
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_p <= RST_VAL;
            r_n <= ~RST_VAL;
        end else begin
            r_p <= i_d;
            r_n <= ~i_d;
        end

    assign o_p = r_p;
    assign o_n = r_n;
`endif

endmodule

// File: rtl/hdmiext_serout.sv
// hdmiext_serout: TMDS lane serialiser with idle-word underflow fill and clock lane (pads via hdmiext_pad_diff, HDMIEXT_SEROUT_OBUFDS_EN)
module hdmiext_serout
    import hdmiext_pkg::*;
#(
    parameter int                NUM_CH    = 3,
    parameter int                WORD_W    = 10,
    parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(CTRL0),
    parameter int                UFLOW_W   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [NUM_CH*WORD_W-1:0] i_in_data,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    output logic                     o_word_start,
    output logic [UFLOW_W-1:0]       o_uflow_cnt,
    input  logic                     i_uflow_clr,
    output logic [NUM_CH-1:0]        o_tmds_p,
    output logic [NUM_CH-1:0]        o_tmds_n,
    output logic                     o_tmds_clk_p,
    output logic                     o_tmds_clk_n
);

    localparam int BW = $clog2(WORD_W);

    logic [BW-1:0]              r_bcnt;
    logic                       r_en_q;
    logic                       r_hold_full;
    logic [NUM_CH*WORD_W-1:0]   r_hold;
    logic [UFLOW_W-1:0]         r_uflow;
    logic [WORD_W-1:0]          r_sh [NUM_CH];

    logic w_load;
    logic w_acc;
    logic w_take;
    logic w_uf;
    logic w_clk_bit;

    assign w_load       = r_bcnt == BW'(WORD_W - 1);
    assign o_in_ready   = !r_hold_full || (w_load && r_en_q);
    assign w_acc        = i_in_valid && o_in_ready;
    assign w_take       = w_load && r_en_q && r_hold_full;
    assign w_uf         = w_load && r_en_q && !r_hold_full;
    assign w_clk_bit    = r_bcnt < BW'(WORD_W / 2);
    assign o_word_start = r_bcnt == '0;
    assign o_uflow_cnt  = r_uflow;

    // bit counter, enable sample, holding register and underflow counter
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_bcnt      <= '0;
            r_en_q      <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold      <= '0;
            r_uflow     <= '0;
        end else begin
            r_bcnt      <= w_load ? '0 : r_bcnt + 1'b1;
            r_en_q      <= i_en;
            r_hold_full <= w_acc || (r_hold_full && !w_take);
            if (w_acc) r_hold <= i_in_data;
            r_uflow     <= i_uflow_clr ? '0 : (w_uf && !(&r_uflow)) ? r_uflow + 1'b1 : r_uflow;
        end

    // per-lane shifters: reload at word boundary (held word or idle fill), else shift LSB-first
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) r_sh[c] <= IDLE_WORD;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                r_sh[c] <= w_load ? (w_take ? r_hold[c*WORD_W +: WORD_W] : IDLE_WORD) : r_sh[c] >> 1;
        end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        hdmiext_pad_diff #(.RST_VAL(IDLE_WORD[0])) u_pad (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_d     (r_sh[g][0]),
            .o_p     (o_tmds_p[g]),
            .o_n     (o_tmds_n[g])
        );
    end

    hdmiext_pad_diff #(.RST_VAL(1'b1)) u_clk_pad (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_clk_bit),
        .o_p     (o_tmds_clk_p),
        .o_n     (o_tmds_clk_n)
    );

endmodule
